key_matrix_scan: RTL and testbench

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

---
 rtl/key_matrix_scan_pkg.sv | 30 +++
 rtl/key_debounce.sv | 74 +++++++
 rtl/key_matrix_scan.sv | 81 ++++++++
 tb/tb_key_matrix_scan.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/key_matrix_scan_pkg.sv
// Shared definitions for the 4x4 key matrix scanner.
// Holds the matrix geometry, the key code width, the default debounce depth,
// the debounce FSM state encoding and the per-frame scan result type.
package key_matrix_scan_pkg;

  localparam int unsigned ROWS          = 4;
  localparam int unsigned COLS          = 4;
  localparam int unsigned CODE_W        = 4;
  localparam int unsigned DEB_SCANS_DEF = 4;
  localparam int unsigned CNT_W         = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } deb_state_t;

  typedef struct packed {
    logic              pressed;
    logic [CODE_W-1:0] code;
  } frame_t;

  // Index of the lowest-numbered row reading low (active-low rows).
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows);
    lowest_low_row = 2'd0;
    for (int unsigned i = ROWS; i > 0; i--) begin
      if (!rows[i-1]) lowest_low_row = 2'(i - 1);
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debouncer for the key matrix scanner.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   frame_end   - one-clock strobe marking a completed scan frame
//   frame_res   - result of that frame {pressed, code}
//   key_code    - last accepted key code
//   key_valid   - one-clock pulse on an accepted press
//   key_held    - high from accepted press until accepted release
module key_debounce
  import key_matrix_scan_pkg::*;
#(
  parameter int unsigned DEB_SCANS = DEB_SCANS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_end,
  input  frame_t            frame_res,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEB_SCANS);

  frame_t           prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             same;
  logic             stable;
  deb_state_t       state;

  always_comb begin
    same     = (frame_res == prev);
    cnt_next = CNT_W'(1);
    if (same) cnt_next = (cnt == DEB_CNT) ? cnt : cnt + CNT_W'(1);
    stable   = (cnt_next == DEB_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      cnt       <= '0;
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        cnt <= cnt_next;
        if (!same) prev <= frame_res;
        case (state)
          IDLE: begin
            if (stable && frame_res.pressed) begin
              state     <= HELD;
              key_code  <= frame_res.code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end
          end
          HELD: begin
            // Only a stable empty frame leaves HELD; a different stable key is ignored.
            if (stable && !frame_res.pressed) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner with frame-based debounce.
// Ports:
//   i_clk       - system clock
//   i_rstn      - asynchronous active-low reset
//   i_pls_1k    - one-clock scan tick strobe
//   i_key_row   - active-low row returns (asynchronous)
//   o_key_col   - active-low column drive, one bit low
//   o_key_code  - last accepted key code {row, col}
//   o_key_valid - one-clock pulse on accepted press
//   o_key_held  - high while a key is accepted as held
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int unsigned DEB_SCANS = DEB_SCANS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_pls_1k,
  input  logic [ROWS-1:0]   i_key_row,
  output logic [COLS-1:0]   o_key_col,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  output logic              o_key_held
);

  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;
  logic [1:0]      col_idx;
  logic [1:0]      col_next;
  frame_t          acc;
  frame_t          sample_res;
  logic [3:0]      cand;
  logic            frame_end;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= i_key_row;
      row_sync <= row_meta;
    end
  end

  // Merge the current column's sample into the partial frame; the smallest
  // {row, col} value found low wins, so simultaneous keys resolve deterministically.
  always_comb begin
    cand       = {lowest_low_row(row_sync), col_idx};
    sample_res = acc;
    if (!(&row_sync) && (!acc.pressed || cand < acc.code)) begin
      sample_res = '{pressed: 1'b1, code: cand};
    end
    frame_end = i_pls_1k && (col_idx == 2'd3);
    col_next  = col_idx + 2'd1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col_idx   <= '0;
      o_key_col <= 4'b1110;
      acc       <= '0;
    end else if (i_pls_1k) begin
      col_idx   <= col_next;
      o_key_col <= ~(4'b0001 << col_next);
      acc       <= frame_end ? '0 : sample_res;
    end
  end

  key_debounce #(
    .DEB_SCANS(DEB_SCANS)
  ) u_debounce (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .frame_end (frame_end),
    .frame_res (sample_res),
    .key_code  (o_key_code),
    .key_valid (o_key_valid),
    .key_held  (o_key_held)
  );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed self-checking bench for key_matrix_scan with a behavioural 4x4 keypad.
module tb_key_matrix_scan;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        pls = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;   // bit {row,col} set = key pressed

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = '1;
    for (int r = 0; r < 4; r++) begin
      key_row[r] = ~|(keys[r*4 +: 4] & ~key_col);
    end
  end

  key_matrix_scan #(
    .DEB_SCANS(4)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_pls_1k    (pls),
    .i_key_row   (key_row),
    .o_key_col   (key_col),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .o_key_held  (key_held)
  );

  // One scan tick followed by a settle gap; counts clocks with valid high.
  task automatic tick(output int v);
    v = 0;
    @(negedge clk) pls = 1'b1;
    @(negedge clk) pls = 1'b0;
    if (key_valid) v++;
    repeat (6) begin
      @(negedge clk);
      if (key_valid) v++;
    end
  endtask

  task automatic run_frames(input int n, output int v);
    int t;
    v = 0;
    for (int i = 0; i < 4 * n; i++) begin
      tick(t);
      v += t;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col [4];
    int v;
    int vsum;
    exp_col[0] = 4'b1101; exp_col[1] = 4'b1011;
    exp_col[2] = 4'b0111; exp_col[3] = 4'b1110;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (key_col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected %b", key_col, 4'b1110); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected %h", key_code, 4'h0); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", key_valid, 1'b0); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected %b", key_held, 1'b0); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    vsum = 0;
    for (int i = 0; i < 4; i++) begin
      tick(v);
      vsum += v;
      checks++; if (key_col !== exp_col[i]) begin errors++; $display("FAIL col_seq[%0d]: got %b expected %b", i, key_col, exp_col[i]); end
    end
    checks++; if (vsum !== 0 || key_held !== 1'b0) begin errors++; $display("FAIL idle_outputs: valids %0d held %b expected 0 0", vsum, key_held); end
  endtask

  task automatic test_press;
    int v;
    keys = '0; keys[6] = 1'b1;
    run_frames(3, v);
    checks++; if (v !== 0 || key_held !== 1'b0) begin errors++; $display("FAIL press_early: valids %0d held %b expected 0 0", v, key_held); end
    run_frames(1, v);
    checks++; if (v !== 1) begin errors++; $display("FAIL press_valid: got %0d pulses expected 1", v); end
    checks++; if (key_code !== 4'h6 || key_held !== 1'b1) begin errors++; $display("FAIL press_code: code %h held %b expected 6 1", key_code, key_held); end
  endtask

  task automatic test_release;
    int v;
    int v2;
    keys = '0;
    run_frames(3, v);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early: held %b expected 1", key_held); end
    run_frames(1, v2);
    checks++; if (key_held !== 1'b0 || (v + v2) !== 0 || key_code !== 4'h6) begin errors++; $display("FAIL release: held %b valids %0d code %h expected 0 0 6", key_held, v + v2, key_code); end
  endtask

  task automatic test_bounce;
    int v;
    int v2;
    keys = '0; keys[6] = 1'b1;
    run_frames(3, v);
    keys = '0;
    run_frames(4, v2);
    checks++; if ((v + v2) !== 0 || key_held !== 1'b0) begin errors++; $display("FAIL bounce: valids %0d held %b expected 0 0", v + v2, key_held); end
  endtask

  task automatic test_multi;
    int v;
    keys = '0; keys[6] = 1'b1; keys[9] = 1'b1;
    run_frames(4, v);
    checks++; if (v !== 1 || key_code !== 4'h6) begin errors++; $display("FAIL multi_accept: valids %0d code %h expected 1 6", v, key_code); end
    keys[6] = 1'b0;
    run_frames(5, v);
    checks++; if (v !== 0 || key_code !== 4'h6 || key_held !== 1'b1) begin errors++; $display("FAIL multi_change: valids %0d code %h held %b expected 0 6 1", v, key_code, key_held); end
  endtask

  task automatic test_repress;
    int v;
    keys = '0;
    run_frames(4, v);
    checks++; if (v !== 0 || key_held !== 1'b0) begin errors++; $display("FAIL repress_release: valids %0d held %b expected 0 0", v, key_held); end
    keys[9] = 1'b1;
    run_frames(4, v);
    checks++; if (v !== 1 || key_code !== 4'h9 || key_held !== 1'b1) begin errors++; $display("FAIL repress: valids %0d code %h held %b expected 1 9 1", v, key_code, key_held); end
  endtask

  task automatic test_reset_mid;
    int v;
    tick(v);
    tick(v);
    @(negedge clk) rstn = 1'b0;
    #1;
    checks++; if (key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0 || key_col !== 4'b1110) begin
      errors++; $display("FAIL mid_reset: held %b valid %b code %h col %b expected 0 0 0 1110", key_held, key_valid, key_code, key_col);
    end
    @(negedge clk) rstn = 1'b1;
    repeat (4) @(negedge clk);
    run_frames(3, v);
    checks++; if (v !== 0 || key_held !== 1'b0) begin errors++; $display("FAIL post_reset_early: valids %0d held %b expected 0 0", v, key_held); end
    run_frames(1, v);
    checks++; if (v !== 1 || key_code !== 4'h9 || key_held !== 1'b1) begin errors++; $display("FAIL post_reset_accept: valids %0d code %h held %b expected 1 9 1", v, key_code, key_held); end
  endtask

  initial begin
    test_reset;
    test_press;
    test_release;
    test_bounce;
    test_multi;
    test_repress;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
